// File: rtl/relm_vga_io.sv
// relm_vga_io: VGA scan-out with a CPU-fed pixel FIFO and a 256-entry palette.
//   clk, rst_n_in      : single clock, synchronous active-low reset
//   vga_d_in           : pixel word push ([WD] strobe), vga_retry_out high when FIFO full
//   pal_d_in           : palette write ([WD] strobe, [7:0] index, [8+:3*WCOL] RGB)
//   ctl_d_in           : control ([WD] strobe, [0] enable, [1] 8bpp mode, [2] flush)
//   stat_d_in          : status read strobe, clears underrun
//   stat_q_out         : {level @16, line @2, underrun @1, vblank @0}
//   vga_r/g/b_out      : colour, vga_s_out {VSYNC, HSYNC}; registered, 2 clk after tick
module relm_vga_io #(
  parameter int WD       = 32,
  parameter int WAD      = 8,
  parameter int WCOL     = 4,
  parameter int CLKDIV   = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic            clk,
  input  logic            rst_n_in,
  input  logic [WD:0]     vga_d_in,
  output logic            vga_retry_out,
  input  logic [WD:0]     pal_d_in,
  input  logic [WD:0]     ctl_d_in,
  input  logic [WD:0]     stat_d_in,
  output logic [WD:0]     stat_q_out,
  output logic [WCOL-1:0] vga_r_out,
  output logic [WCOL-1:0] vga_g_out,
  output logic [WCOL-1:0] vga_b_out,
  output logic [1:0]      vga_s_out
);
  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(HT + 1);
  localparam int VW    = $clog2(VT + 1);
  localparam int DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int DEPTH = 1 << WAD;
  localparam int PW    = $clog2(WD / 4);
  localparam int CW    = 3 * WCOL;

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_S   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_A   = (HS_POL != 0);
  localparam logic          VS_A   = (VS_POL != 0);

  // ---------------- timing ----------------
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick, frame_start;

  assign tick        = (div == DW'(CLKDIV - 1));
  assign frame_start = tick && (h == '0) && (v == '0);

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // ---------------- control ----------------
  logic en_reg, mode_reg, en_lat, mode_lat, en_cur, mode_cur, flush, underrun;

  assign flush = ctl_d_in[WD] & ctl_d_in[2];
  // The frame-start pixel already uses the freshly latched settings.
  assign en_cur   = frame_start ? en_reg   : en_lat;
  assign mode_cur = frame_start ? mode_reg : mode_lat;

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      en_reg   <= 1'b0;
      mode_reg <= 1'b0;
      en_lat   <= 1'b0;
      mode_lat <= 1'b0;
    end else begin
      if (ctl_d_in[WD]) begin
        en_reg   <= ctl_d_in[0];
        mode_reg <= ctl_d_in[1];
      end
      if (frame_start) begin
        en_lat   <= en_reg;
        mode_lat <= mode_reg;
      end
    end
  end

  // ---------------- pixel FIFO ----------------
  logic [WD-1:0]  mem [DEPTH];
  logic [WAD-1:0] wp, rp;
  logic [WAD:0]   level;
  logic           full, empty, push, pop, need;

  assign full  = (level == (WAD+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = vga_d_in[WD] & ~full & ~flush;
  assign pop   = need & ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= vga_d_in[WD-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // ---------------- unpacker ----------------
  // sh_word holds the current word left-aligned; the next pixel is always its top bits.
  logic [PW-1:0] pix_cnt, pix_cur, pix_last;
  logic [WD-1:0] sh_word, src;
  logic          wvalid, src_valid, act_pix, hs_on, vs_on;
  logic [7:0]    idx;

  assign act_pix   = (h < H_ACT) && (v < V_ACT) && en_cur;
  assign pix_cur   = frame_start ? '0 : pix_cnt;
  assign pix_last  = mode_cur ? PW'(WD / 8 - 1) : PW'(WD / 4 - 1);
  assign need      = tick && act_pix && (pix_cur == '0);
  assign src       = need ? mem[rp] : sh_word;
  assign src_valid = need ? ~empty : wvalid;
  assign hs_on     = (h >= HS_S) && (h < HS_E);
  assign vs_on     = (v >= VS_S) && (v < VS_E);

  always_comb begin
    idx = '0;
    if (src_valid) idx = mode_cur ? src[WD-1 -: 8] : {4'b0, src[WD-1 -: 4]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      pix_cnt <= '0;
      sh_word <= '0;
      wvalid  <= 1'b0;
    end else begin
      if (tick && act_pix) begin
        pix_cnt <= (pix_cur == pix_last) ? '0 : pix_cur + 1'b1;
        sh_word <= mode_cur ? (src << 8) : (src << 4);
        wvalid  <= src_valid;
      end else if (frame_start) begin
        pix_cnt <= '0;
      end
      if (flush) wvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in)         underrun <= 1'b0;
    else if (need & empty) underrun <= 1'b1;
    else if (stat_d_in[WD]) underrun <= 1'b0;
  end

  // ---------------- output pipeline ----------------
  logic [CW-1:0] pal [256];
  logic          s1_vld, s1_act, s1_hs, s1_vs;
  logic [7:0]    s1_idx;

  // Palette read happens on the same edge as a write, so it sees the old entry.
  always_ff @(posedge clk) begin
    if (pal_d_in[WD]) pal[pal_d_in[7:0]] <= pal_d_in[8 +: CW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      s1_vld <= 1'b0;
      s1_act <= 1'b0;
      s1_idx <= '0;
      s1_hs  <= ~HS_A;
      s1_vs  <= ~VS_A;
    end else begin
      s1_vld <= tick;
      if (tick) begin
        s1_act <= act_pix;
        s1_idx <= idx;
        s1_hs  <= hs_on ? HS_A : ~HS_A;
        s1_vs  <= vs_on ? VS_A : ~VS_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      {vga_r_out, vga_g_out, vga_b_out} <= '0;
      vga_s_out <= {~VS_A, ~HS_A};
    end else if (s1_vld) begin
      {vga_r_out, vga_g_out, vga_b_out} <= s1_act ? pal[s1_idx] : '0;
      vga_s_out <= {s1_vs, s1_hs};
    end
  end

  // ---------------- status ----------------
  assign vga_retry_out = full;

  always_comb begin
    stat_q_out            = '0;
    stat_q_out[0]         = (v >= V_ACT);
    stat_q_out[1]         = underrun;
    stat_q_out[2 +: 10]   = 10'(v);
    stat_q_out[16 +: WAD+1] = level;
  end

  logic unused_bits;
  assign unused_bits = ^{pal_d_in[WD-1:8+CW], ctl_d_in[WD-1:3], stat_d_in[WD-1:0]};
endmodule
